// File: rtl/imem_fetch_arbiter_if.sv
// Bundle of the IF-stage, debug-burst and instruction-ROM signals around imem_fetch_arbiter.
// The arbiter uses the slave modport; requesters and the ROM model sit on the master side.
interface imem_fetch_arbiter_if #(
    parameter int unsigned LEN_W = 11
);
    logic             if_req;
    logic [31:0]      if_addr;
    logic             if_gnt;
    logic             if_valid;
    logic [31:0]      if_data;
    logic             if_err;

    logic             dbg_start;
    logic [31:0]      dbg_base;
    logic [LEN_W-1:0] dbg_len;
    logic             dbg_abort;
    logic             dbg_busy;
    logic             dbg_valid;
    logic [31:0]      dbg_data;
    logic             dbg_err;
    logic             dbg_done;

    logic             mem_ce;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_data;

    modport slave (
        input  if_req, if_addr, dbg_start, dbg_base, dbg_len, dbg_abort, mem_data,
        output if_gnt, if_valid, if_data, if_err,
        output dbg_busy, dbg_valid, dbg_data, dbg_err, dbg_done,
        output mem_ce, mem_addr
    );

    modport master (
        output if_req, if_addr, dbg_start, dbg_base, dbg_len, dbg_abort, mem_data,
        input  if_gnt, if_valid, if_data, if_err,
        input  dbg_busy, dbg_valid, dbg_data, dbg_err, dbg_done,
        input  mem_ce, mem_addr
    );
endinterface

// File: rtl/imem_fetch_arbiter.sv
// Shares the instruction ROM port between single-word IF fetches and debug burst reads,
// with per-cycle arbitration, a starvation limit for debug, and registered responses.
module imem_fetch_arbiter #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned STARVE_MAX  = 4,
    parameter int unsigned LEN_W       = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    imem_fetch_arbiter_if.slave  bus
);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e           state_q, state_d;
    logic [31:0]      cur_q, cur_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             dbg_done_d;

    logic             if_valid_q, if_err_q, dbg_valid_q, dbg_err_q, dbg_done_q;
    logic [31:0]      if_data_q, dbg_data_q;

    logic             fetch_win, dbg_win, fetch_ok, dbg_ok;

    function automatic logic in_range(input logic [31:0] addr);
        return 32'(addr[31:2]) < DEPTH_WORDS;
    endfunction

    assign fetch_ok = (bus.if_addr[1:0] == 2'b00) && in_range(bus.if_addr);
    assign dbg_ok   = in_range(cur_q);

    // Gated by rst_n so no grant or chip enable leaks out while reset is held.
    always_comb begin
        fetch_win = 1'b0;
        dbg_win   = 1'b0;
        if (rst_n) begin
            if (state_q == StIdle) begin
                fetch_win = bus.if_req;
            end else begin
                fetch_win = bus.if_req && (starve_q < SW'(STARVE_MAX));
                dbg_win   = !fetch_win && !bus.dbg_abort;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        rem_d      = rem_q;
        starve_d   = starve_q;
        dbg_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                starve_d = '0;
                if (bus.dbg_start) begin
                    cur_d = bus.dbg_base & ~32'h3;
                    rem_d = bus.dbg_len;
                    if (bus.dbg_len == '0) begin
                        dbg_done_d = 1'b1;
                    end else begin
                        state_d = StBurst;
                    end
                end
            end
            StBurst: begin
                if (bus.dbg_abort) begin
                    state_d    = StIdle;
                    starve_d   = '0;
                    dbg_done_d = 1'b1;
                end else if (fetch_win) begin
                    starve_d = starve_q + SW'(1);
                end else begin
                    starve_d = '0;
                    cur_d    = cur_q + 32'd4;
                    rem_d    = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d    = StIdle;
                        dbg_done_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // A granted slot with a bad address is consumed without touching the ROM.
    always_comb begin
        bus.mem_ce   = 1'b0;
        bus.mem_addr = '0;
        if (fetch_win && fetch_ok) begin
            bus.mem_ce   = 1'b1;
            bus.mem_addr = bus.if_addr;
        end else if (dbg_win && dbg_ok) begin
            bus.mem_ce   = 1'b1;
            bus.mem_addr = cur_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cur_q       <= '0;
            rem_q       <= '0;
            starve_q    <= '0;
            if_valid_q  <= 1'b0;
            if_err_q    <= 1'b0;
            if_data_q   <= '0;
            dbg_valid_q <= 1'b0;
            dbg_err_q   <= 1'b0;
            dbg_data_q  <= '0;
            dbg_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            rem_q       <= rem_d;
            starve_q    <= starve_d;
            if_valid_q  <= fetch_win;
            if_err_q    <= fetch_win && !fetch_ok;
            dbg_valid_q <= dbg_win;
            dbg_err_q   <= dbg_win && !dbg_ok;
            dbg_done_q  <= dbg_done_d;
            if (fetch_win) begin
                if_data_q <= fetch_ok ? bus.mem_data : '0;
            end
            if (dbg_win) begin
                dbg_data_q <= dbg_ok ? bus.mem_data : '0;
            end
        end
    end

    assign bus.if_gnt    = fetch_win;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_data   = if_data_q;
    assign bus.if_err    = if_err_q;
    assign bus.dbg_busy  = (state_q == StBurst);
    assign bus.dbg_valid = dbg_valid_q;
    assign bus.dbg_data  = dbg_data_q;
    assign bus.dbg_err   = dbg_err_q;
    assign bus.dbg_done  = dbg_done_q;
endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench for imem_fetch_arbiter: per-cycle vector table plus hand-written
// sequences for starvation, abort and asynchronous reset.
module tb_imem_fetch_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    imem_fetch_arbiter_if #(.LEN_W(11)) bus ();

    imem_fetch_arbiter #(
        .DEPTH_WORDS(1024),
        .STARVE_MAX (4),
        .LEN_W      (11)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'hDA7A_0000 | {2'b00, a[31:2]};
    endfunction

    assign bus.mem_data = rom(bus.mem_addr);

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        start;
        logic [31:0] base;
        logic [10:0] len;
        logic        abort;
        logic        gnt;
        logic        ce;
        logic [31:0] maddr;
        logic        ivld;
        logic [31:0] idata;
        logic        ierr;
        logic        dvld;
        logic [31:0] ddata;
        logic        derr;
        logic        done;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic req, input logic [31:0] addr, input logic start, input logic [31:0] base,
        input logic [10:0] len, input logic abort, input logic gnt, input logic ce,
        input logic [31:0] maddr, input logic ivld, input logic [31:0] idata, input logic ierr,
        input logic dvld, input logic [31:0] ddata, input logic derr, input logic done,
        input logic busy);
        vec_t v;
        v.req = req;   v.addr = addr;   v.start = start; v.base = base;
        v.len = len;   v.abort = abort; v.gnt = gnt;     v.ce = ce;
        v.maddr = maddr; v.ivld = ivld; v.idata = idata; v.ierr = ierr;
        v.dvld = dvld; v.ddata = ddata; v.derr = derr;   v.done = done;
        v.busy = busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic req, input logic [31:0] addr, input logic start,
                         input logic [31:0] base, input logic [10:0] len, input logic abort);
        bus.if_req    = req;
        bus.if_addr   = addr;
        bus.dbg_start = start;
        bus.dbg_base  = base;
        bus.dbg_len   = len;
        bus.dbg_abort = abort;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit exp_g[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        int dv_cnt;
        int stray;

        // req   addr          st base          len     ab gnt ce maddr
        //   ivld idata                ierr dvld ddata               derr done busy
        vecs.push_back(mk(1, 32'h0, 0, 0, 11'd0, 0, 1, 1, 32'h0,
                          1, 32'hDA7A_0000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h4, 0, 0, 11'd0, 0, 1, 1, 32'h4,
                          1, 32'hDA7A_0001, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h8, 0, 0, 11'd0, 0, 1, 1, 32'h8,
                          1, 32'hDA7A_0002, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h6, 0, 0, 11'd0, 0, 1, 0, 32'h0,
                          1, 32'h0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h1000, 0, 0, 11'd0, 0, 1, 0, 32'h0,
                          1, 32'h0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'hFFC, 0, 0, 11'd0, 0, 1, 1, 32'hFFC,
                          1, 32'hDA7A_03FF, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0, 1, 32'h13, 11'd3, 0, 0, 0, 32'h0,
                          0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 32'h0, 0, 0, 11'd0, 0, 0, 1, 32'h10,
                          0, 0, 0, 1, 32'hDA7A_0004, 0, 0, 1));
        vecs.push_back(mk(0, 32'h0, 0, 0, 11'd0, 0, 0, 1, 32'h14,
                          0, 0, 0, 1, 32'hDA7A_0005, 0, 0, 1));
        vecs.push_back(mk(0, 32'h0, 1, 32'h100, 11'd5, 0, 0, 1, 32'h18,
                          0, 0, 0, 1, 32'hDA7A_0006, 0, 1, 0));
        vecs.push_back(mk(0, 32'h0, 0, 0, 11'd0, 0, 0, 0, 32'h0,
                          0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0, 1, 32'h40, 11'd0, 0, 0, 0, 32'h0,
                          0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 32'h0, 0, 0, 11'd0, 0, 0, 0, 32'h0,
                          0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0, 1, 32'hFFC, 11'd2, 0, 0, 0, 32'h0,
                          0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 32'h0, 0, 0, 11'd0, 0, 0, 1, 32'hFFC,
                          0, 0, 0, 1, 32'hDA7A_03FF, 0, 0, 1));
        vecs.push_back(mk(0, 32'h0, 0, 0, 11'd0, 0, 0, 0, 32'h0,
                          0, 0, 0, 1, 32'h0, 1, 1, 0));

        // Reset state, with a fetch request asserted to show the grant is held off.
        drive(1, 32'h0, 0, 0, 11'd0, 0);
        #2;
        check("rst if_gnt", bus.if_gnt, 0);
        check("rst mem_ce", bus.mem_ce, 0);
        check("rst if_valid", bus.if_valid, 0);
        check("rst dbg_busy", bus.dbg_busy, 0);
        check("rst dbg_done", bus.dbg_done, 0);
        drive(0, 32'h0, 0, 0, 11'd0, 0);
        #10 rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].addr, vecs[i].start, vecs[i].base, vecs[i].len,
                  vecs[i].abort);
            #1;
            check($sformatf("v%0d if_gnt", i), bus.if_gnt, vecs[i].gnt);
            check($sformatf("v%0d mem_ce", i), bus.mem_ce, vecs[i].ce);
            check($sformatf("v%0d mem_addr", i), bus.mem_addr, vecs[i].maddr);
            tick();
            check($sformatf("v%0d if_valid", i), bus.if_valid, vecs[i].ivld);
            check($sformatf("v%0d if_err", i), bus.if_err, vecs[i].ierr);
            if (vecs[i].ivld) check($sformatf("v%0d if_data", i), bus.if_data, vecs[i].idata);
            check($sformatf("v%0d dbg_valid", i), bus.dbg_valid, vecs[i].dvld);
            check($sformatf("v%0d dbg_err", i), bus.dbg_err, vecs[i].derr);
            if (vecs[i].dvld) check($sformatf("v%0d dbg_data", i), bus.dbg_data, vecs[i].ddata);
            check($sformatf("v%0d dbg_done", i), bus.dbg_done, vecs[i].done);
            check($sformatf("v%0d dbg_busy", i), bus.dbg_busy, vecs[i].busy);
        end

        // Starvation: fetch held high, debug gets every fifth slot.
        drive(1, 32'h80, 1, 32'h20, 11'd2, 0);
        #1;
        check("starve start gnt", bus.if_gnt, 1);
        tick();
        drive(1, 32'h80, 0, 0, 11'd0, 0);
        dv_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("starve c%0d gnt", i), bus.if_gnt, 32'(exp_g[i]));
            check($sformatf("starve c%0d mem_addr", i), bus.mem_addr,
                  exp_g[i] ? 32'h80 : 32'h20 + 32'(4 * (i / 5)));
            tick();
            if (bus.dbg_valid) dv_cnt++;
        end
        check("starve dbg_done", bus.dbg_done, 1);
        check("starve dbg_valid", bus.dbg_valid, 1);
        check("starve dbg_data", bus.dbg_data, 32'hDA7A_0009);
        check("starve dbg_busy", bus.dbg_busy, 0);
        check("starve word count", dv_cnt, 2);

        // Abort after two words; fetch still wins the abort cycle.
        drive(0, 32'h0, 1, 32'h0, 11'd8, 0);
        tick();
        check("abort busy", bus.dbg_busy, 1);
        drive(0, 32'h0, 0, 0, 11'd0, 0);
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("abort w%0d mem_addr", i), bus.mem_addr, 32'(4 * i));
            tick();
            check($sformatf("abort w%0d dbg_valid", i), bus.dbg_valid, 1);
        end
        drive(1, 32'h44, 0, 0, 11'd0, 1);
        #1;
        check("abort if_gnt", bus.if_gnt, 1);
        check("abort mem_addr", bus.mem_addr, 32'h44);
        tick();
        check("abort dbg_done", bus.dbg_done, 1);
        check("abort dbg_valid", bus.dbg_valid, 0);
        check("abort dbg_busy", bus.dbg_busy, 0);
        check("abort if_data", bus.if_data, 32'hDA7A_0011);
        // Abort while idle is ignored and the dead burst stays silent.
        drive(0, 32'h0, 0, 0, 11'd0, 1);
        stray = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.dbg_valid || bus.dbg_done) stray++;
        end
        check("abort no stray output", stray, 0);

        // Asynchronous reset in the middle of a burst.
        drive(0, 32'h0, 1, 32'h200, 11'd8, 0);
        tick();
        drive(0, 32'h0, 0, 0, 11'd0, 0);
        tick();
        check("mid-burst dbg_valid", bus.dbg_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst dbg_busy", bus.dbg_busy, 0);
        check("async rst dbg_valid", bus.dbg_valid, 0);
        check("async rst dbg_data", bus.dbg_data, 0);
        drive(1, 32'hC, 0, 0, 11'd0, 0);
        #1;
        check("async rst if_gnt", bus.if_gnt, 0);
        check("async rst mem_ce", bus.mem_ce, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post rst if_gnt", bus.if_gnt, 1);
        check("post rst mem_addr", bus.mem_addr, 32'hC);
        tick();
        check("post rst if_valid", bus.if_valid, 1);
        check("post rst if_data", bus.if_data, 32'hDA7A_0003);
        check("post rst dbg_busy", bus.dbg_busy, 0);
        drive(0, 32'h0, 0, 0, 11'd0, 0);
        tick();
        check("post rst dbg_done", bus.dbg_done, 0);
        check("post rst dbg_valid", bus.dbg_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
